// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment display: special codes,
// segment patterns (bit 0 = segment a) and the hex glyph lookup.
package display_pkg;

  localparam logic [4:0] CODE_DASH  = 5'd16;
  localparam logic [4:0] CODE_BLANK = 5'd17;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 5-bit display code to active-high segment pattern.
// Codes 0-15 are hex glyphs, 16 is a dash, everything else is blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    if (code < CODE_DASH)
      seg = hex_glyph(code[3:0]);
    else if (code == CODE_DASH)
      seg = SEG_DASH;
    else
      seg = SEG_BLANK;
  end

endmodule

// File: rtl/display_mux_n.sv
// Time-multiplexed N-digit seven-segment driver with per-frame shadowing and dead time.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zeros.
module display_mux_n
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 3,
  parameter int DIV         = 1000,
  parameter int DEAD_CYC    = 2,
  parameter int SEG_ACT_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5*N_DIGITS-1:0] codes,
  input  logic [N_DIGITS-1:0]   dp,
  output logic [N_DIGITS-1:0]   enable,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic                  frame_tick
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [6:0]    SEG_POL  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic          DP_POL   = (SEG_ACT_LOW != 0);
  localparam logic [N_DIGITS-1:0] EN_ONE = N_DIGITS'(1);

  logic [CW-1:0]         cnt, cnt_next;
  logic [IW-1:0]         idx, idx_next;
  logic [5*N_DIGITS-1:0] sh_codes, sh_codes_next;
  logic [N_DIGITS-1:0]   sh_dp, sh_dp_next;
  logic                  slot_wrap, frame_wrap, dead;
  logic [4:0]            sel_code, show_code;
  logic                  sel_dp;
  logic [6:0]            glyph;

  // Outputs are registered from next-state values so that enable, seg and
  // dp_out line up exactly with the cnt/idx/shadow state of the same cycle.
  always_comb begin
    slot_wrap     = (cnt == CNT_LAST);
    frame_wrap    = slot_wrap && (idx == IDX_LAST);
    cnt_next      = slot_wrap ? '0 : cnt + 1'b1;
    idx_next      = idx;
    if (slot_wrap)
      idx_next = frame_wrap ? '0 : idx + 1'b1;
    sh_codes_next = frame_wrap ? codes : sh_codes;
    sh_dp_next    = frame_wrap ? dp : sh_dp;
    dead          = (cnt_next < DEAD_END);
    sel_code      = CODE_BLANK;
    sel_dp        = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_next == IW'(k)) begin
        sel_code = sh_codes_next[5*k +: 5];
        sel_dp   = sh_dp_next[k];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic       above_nz;
  logic [4:0] probe;

  // A zero is leading when no higher digit holds a visible code (1..16).
  always_comb begin
    above_nz = 1'b0;
    probe    = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      probe = sh_codes_next[5*k +: 5];
      if (IW'(k) > idx_next && probe != 5'd0 && probe <= CODE_DASH)
        above_nz = 1'b1;
    end
    show_code = (sel_code == 5'd0 && idx_next != '0 && !above_nz) ? CODE_BLANK : sel_code;
  end
`else
  assign show_code = sel_code;
`endif

  seg7_decode u_decode (
    .code (show_code),
    .seg  (glyph)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      sh_codes   <= {N_DIGITS{CODE_BLANK}};
      sh_dp      <= '0;
      enable     <= '0;
      seg        <= SEG_BLANK ^ SEG_POL;
      dp_out     <= DP_POL;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      idx        <= idx_next;
      sh_codes   <= sh_codes_next;
      sh_dp      <= sh_dp_next;
      frame_tick <= frame_wrap;
      enable     <= dead ? '0 : (EN_ONE << idx_next);
      seg        <= (dead ? SEG_BLANK : glyph) ^ SEG_POL;
      dp_out     <= (dead ? 1'b0 : sel_dp) ^ DP_POL;
    end
  end

endmodule
